// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction fetch with icache lookup, byte-serial miss fill and prefetch FIFO
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] ic_raddr,
  input  logic        ic_hit,
  input  logic [31:0] ic_rdata,
  output logic        ic_we,
  output logic [31:0] ic_waddr,
  output logic [31:0] ic_wdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {LOOKUP, MISS} state_t;

  state_t      state;
  logic [31:0] fpc;
  logic [2:0]  issue_idx;
  logic [1:0]  recv_idx;
  logic [23:0] asm_buf;
  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic        pop;
  logic        space;
  logic        hit_push;
  logic        miss_done;
  logic        push;
  logic [31:0] miss_word;
  logic [31:0] push_inst;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign space     = (count != (AW+1)'(DEPTH)) || pop;
  assign miss_word = {mem_rdata, asm_buf};
  assign hit_push  = (state == LOOKUP) && space && ic_hit;
  assign miss_done = (state == MISS) && mem_rvalid && (recv_idx == 2'd3);
  assign push      = hit_push || miss_done;
  assign push_inst = (state == MISS) ? miss_word : ic_rdata;

  // Requests stop once all four bytes are granted; redirect suppresses the request it would abort.
  assign mem_req  = (state == MISS) && !issue_idx[2] && !redirect_valid;
  assign mem_addr = fpc + {29'd0, issue_idx};
  assign ic_raddr = fpc;

  assign out_pc   = out_valid ? q_pc[rd_ptr]   : '0;
  assign out_inst = out_valid ? q_inst[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      q_pc[wr_ptr]   <= fpc;
      q_inst[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOOKUP;
      fpc       <= RESET_PC;
      issue_idx <= '0;
      recv_idx  <= '0;
      asm_buf   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ic_we     <= 1'b0;
      ic_waddr  <= '0;
      ic_wdata  <= '0;
    end else begin
      ic_we <= 1'b0;
      if (redirect_valid) begin
        state     <= LOOKUP;
        fpc       <= {redirect_pc[31:2], 2'b00};
        issue_idx <= '0;
        recv_idx  <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase

        case (state)
          LOOKUP: begin
            if (space) begin
              if (ic_hit) begin
                fpc <= fpc + 32'd4;
              end else begin
                state     <= MISS;
                issue_idx <= '0;
                recv_idx  <= '0;
              end
            end
          end
          MISS: begin
            if (mem_req && mem_gnt) issue_idx <= issue_idx + 1'b1;
            if (mem_rvalid) begin
              recv_idx <= recv_idx + 1'b1;
              // Little-endian assembly; the fourth byte completes the word directly from mem_rdata.
              case (recv_idx)
                2'd0: asm_buf[7:0]   <= mem_rdata;
                2'd1: asm_buf[15:8]  <= mem_rdata;
                2'd2: asm_buf[23:16] <= mem_rdata;
                default: begin
                  fpc      <= fpc + 32'd4;
                  state    <= LOOKUP;
                  ic_we    <= 1'b1;
                  ic_waddr <= fpc;
                  ic_wdata <= miss_word;
                end
              endcase
            end
          end
          default: state <= LOOKUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - scoreboard bench for if_prefetch_queue with random icache/memory/ID behaviour
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [31:0] ic_raddr;
  logic        ic_hit;
  logic [31:0] ic_rdata;
  logic        ic_we;
  logic [31:0] ic_waddr;
  logic [31:0] ic_wdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ic_raddr(ic_raddr), .ic_hit(ic_hit), .ic_rdata(ic_rdata),
    .ic_we(ic_we), .ic_waddr(ic_waddr), .ic_wdata(ic_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  // Program memory image: every aligned address has a distinct instruction word.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  logic hit_now = 1'b0;
  assign ic_hit   = hit_now;
  assign ic_rdata = word(ic_raddr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;
  int          checks = 0;
  int          errors = 0;
  int          npops = 0;

  logic        cur_rst = 1'b1, cur_hit = 1'b0, cur_gnt = 1'b0, cur_rdy = 1'b0, cur_redir = 1'b0;
  logic [31:0] cur_redir_pc = '0;
  logic        pend_rv = 1'b0;
  logic [7:0]  pend_data = '0;
  logic        hold_prev = 1'b0, redir_prev = 1'b0;
  logic [31:0] hold_pc = '0, hold_inst = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic refill(input logic [31:0] pc0);
    exp_q.delete();
    next_pc = pc0;
    top_up();
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] w;
    if (redir_prev) chk("redir_empty", 32'(out_valid), 32'd0);
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_inst", out_inst, hold_inst);
    end
    if (redirect_valid) begin
      chk("redir_req", 32'(mem_req), 32'd0);
      refill({redirect_pc[31:2], 2'b00});
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      chk("pop_pc", out_pc, e.pc);
      chk("pop_inst", out_inst, e.inst);
      npops++;
      top_up();
    end
    if (ic_we) chk("ic_wdata", ic_wdata, word(ic_waddr));
    if (mem_req && mem_gnt) begin
      w = word({mem_addr[31:2], 2'b00});
      pend_rv   = 1'b1;
      pend_data = w[8*mem_addr[1:0] +: 8];
    end
    hold_prev  = out_valid && !out_ready && !redirect_valid;
    hold_pc    = out_pc;
    hold_inst  = out_inst;
    redir_prev = redirect_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst            = cur_rst;
    mem_rvalid     = pend_rv;
    mem_rdata      = pend_data;
    pend_rv        = 1'b0;
    hit_now        = cur_hit;
    mem_gnt        = cur_gnt;
    out_ready      = cur_rdy;
    redirect_valid = cur_redir;
    redirect_pc    = cur_redir_pc;
    @(negedge clk);
    if (rst) begin
      refill(32'h0);
      pend_rv    = 1'b0;
      hold_prev  = 1'b0;
      redir_prev = 1'b0;
    end else begin
      monitor();
    end
  endtask

  task automatic do_reset();
    cur_rst = 1'b1; cur_redir = 1'b0; cur_hit = 1'b0; cur_gnt = 1'b0; cur_rdy = 1'b0;
    step();
    step();
    cur_rst = 1'b0;
  endtask

  initial begin
    int          first_v, first_we, nreq, nwe;
    logic [31:0] req_addr [6];

    do_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ic_raddr", ic_raddr, 32'h0);
    chk("rst_ic_we", 32'(ic_we), 32'd0);
    chk("rst_ic_waddr", ic_waddr, 32'h0);
    chk("rst_ic_wdata", ic_wdata, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);

    // Miss with continuous grant, then with grant denied on the 2nd and 3rd request cycles.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      cur_hit = 1'b0; cur_rdy = 1'b1;
      first_v = -1; first_we = -1; nreq = 0;
      for (int i = 0; i < 12; i++) begin
        cur_gnt = (pass == 1 && (i == 2 || i == 3)) ? 1'b0 : 1'b1;
        step();
        if (out_valid && first_v < 0) first_v = i;
        if (ic_we && first_we < 0) begin
          first_we = i;
          chk("miss_ic_waddr", ic_waddr, 32'h0);
        end
        if (mem_req && nreq < 6) begin
          req_addr[nreq] = mem_addr;
          nreq++;
        end
      end
      chk("miss_first_valid", 32'(first_v), (pass == 0) ? 32'd6 : 32'd8);
      chk("miss_first_we", 32'(first_we), (pass == 0) ? 32'd6 : 32'd8);
      if (pass == 0) begin
        for (int k = 0; k < 4; k++) chk("miss_addr", req_addr[k], 32'(k));
      end else begin
        chk("deny_addr0", req_addr[0], 32'h0);
        chk("deny_addr1", req_addr[1], 32'h1);
        chk("deny_addr2", req_addr[2], 32'h1);
        chk("deny_addr3", req_addr[3], 32'h1);
        chk("deny_addr4", req_addr[4], 32'h2);
        chk("deny_addr5", req_addr[5], 32'h3);
      end
    end

    // All hits, draining every cycle.
    do_reset();
    cur_hit = 1'b1; cur_gnt = 1'b1; cur_rdy = 1'b1;
    first_v = -1; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid && first_v < 0) first_v = i;
      if (mem_req) nreq++;
    end
    chk("hit_first_valid", 32'(first_v), 32'd1);
    chk("hit_no_mem_req", 32'(nreq), 32'd0);

    // Fill to full with no drain, then drain with no gap.
    do_reset();
    cur_hit = 1'b1; cur_rdy = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("full_fpc", ic_raddr, 32'h10);
    chk("full_head", out_pc, 32'h0);
    cur_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_valid", 32'(out_valid), 32'd1);
    end

    // Redirect coinciding with a pop on a full queue.
    cur_rdy = 1'b0;
    for (int i = 0; i < 6; i++) step();
    cur_rdy = 1'b1; cur_redir = 1'b1; cur_redir_pc = 32'h203;
    step();
    cur_redir = 1'b0;
    step();
    chk("redir_lookup", ic_raddr, 32'h200);
    for (int i = 0; i < 6; i++) step();

    // Redirect in the middle of a miss, with a byte arriving in the redirect cycle.
    do_reset();
    cur_hit = 1'b0; cur_gnt = 1'b1; cur_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    cur_redir = 1'b1; cur_redir_pc = 32'h203;
    step();
    cur_redir = 1'b0;
    step();
    chk("abort_lookup", ic_raddr, 32'h200);
    nwe = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ic_we && ic_waddr == 32'h0) nwe++;
    end
    chk("abort_no_we", 32'(nwe), 32'd0);

    // Random traffic.
    do_reset();
    npops = 0;
    for (int i = 0; i < 3000; i++) begin
      cur_hit   = ($urandom_range(0, 99) < 60);
      cur_gnt   = ($urandom_range(0, 99) < 75);
      cur_rdy   = ($urandom_range(0, 99) < 70);
      cur_redir = ($urandom_range(0, 99) < 3);
      cur_redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      step();
    end
    cur_redir = 1'b0;
    step();
    chk("random_progress", 32'(npops > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
